// File: rtl/div_if.sv
// Operand/result bundle between the execute stage (master) and div_unit (slave).
// Handshake: the master raises start_i with operands valid and holds it until it
// sees ready_o; operands are captured on the first accepting edge and later changes
// are ignored. ready_o with result_o stays up while start_i remains high; dropping
// start_i releases the unit back to idle on the next edge.
interface div_if #(
  parameter int WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider, one quotient bit per clock.
// result_o = {remainder, quotient}. Signed operands are divided as magnitudes and
// the signs are fixed up when the result is registered.
// Optional feature: define DIV_ANNUL_EN to let annul_i abort an operation in flight
// and block acceptance while idle; without it annul_i is ignored.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } div_state_e;

  div_state_e          state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    dvd;      // dividend magnitude, quotient bits shift in from the bottom
  logic [WIDTH-1:0]    dsr;      // divisor magnitude
  logic [WIDTH-1:0]    rem;      // partial remainder
  logic                neg_q;
  logic                neg_r;
  logic [2*WIDTH-1:0]  result_q;
  logic                ready_q;

  logic                annul_act;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [WIDTH:0]      rem_sh;
  logic                keep;
  logic [WIDTH-1:0]    diff;
  logic [WIDTH-1:0]    rem_nxt;
  logic [WIDTH-1:0]    q_fin;
  logic [WIDTH-1:0]    r_fin;

`ifdef DIV_ANNUL_EN
  assign annul_act = bus.annul_i;
`else
  logic unused_annul;
  assign annul_act    = 1'b0;
  assign unused_annul = bus.annul_i;
`endif

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign dbg_state    = state;

  // Operand magnitudes, sign-corrected results and one restoring step.
  // The shifted remainder needs WIDTH+1 bits; after a kept subtraction it is
  // below the divisor again, so the low WIDTH bits of the difference suffice.
  always_comb begin
    a_mag   = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    b_mag   = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    rem_sh  = {rem, dvd[WIDTH-1]};
    keep    = (rem_sh >= {1'b0, dsr});
    diff    = rem_sh[WIDTH-1:0] - dsr;
    rem_nxt = keep ? diff : rem_sh[WIDTH-1:0];
    q_fin   = neg_q ? (~dvd + 1'b1) : dvd;
    r_fin   = neg_r ? (~rem + 1'b1) : rem;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !annul_act) begin
            dvd   <= a_mag;
            dsr   <= b_mag;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_r <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            state <= (bus.opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (annul_act) begin
            state <= FREE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state    <= END;
          end
        end
        ON: begin
          if (annul_act) begin
            state <= FREE;
          end else if (cnt == CW'(WIDTH)) begin
            result_q <= {r_fin, q_fin};
            ready_q  <= 1'b1;
            state    <= END;
          end else begin
            rem <= rem_nxt;
            dvd <= {dvd[WIDTH-2:0], keep};
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          if (!bus.start_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state    <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of operations with hand-computed results and
// latencies, plus sequences for reset, annul and hold-in-END behaviour.
module tb_div_unit;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  div_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             sgn;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   exp;
    int               lat;
    int               hold;
  } vec_t;

  vec_t           vecs[12];
  logic [2*W-1:0] exp_q[$];
  int             checks = 0;
  int             errors = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge with start_i low and the unit idle.
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp,
                        input int exp_lat, input int hold);
    int             lat;
    logic [2*W-1:0] exp_v;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check({name, " busy_result"}, bus.result_o, '0);
    bus.opdata1_i    = W'($urandom);
    bus.opdata2_i    = W'($urandom);
    bus.signed_div_i = ~sgn;
    lat = 0;
    while (!bus.ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    check({name, " result"}, bus.result_o, exp_v);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, " hold_ready"}, {63'b0, bus.ready_o}, 64'd1);
      check({name, " hold_result"}, bus.result_o, exp_v);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " release_ready"}, {63'b0, bus.ready_o}, 64'd0);
    check({name, " release_result"}, bus.result_o, '0);
    @(negedge clk);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{"u_100_7",      1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 0};
    vecs[1]  = '{"s_m7_2",       1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33, 0};
    vecs[2]  = '{"u_5_0",        1'b0, 32'd5,          32'd0,          64'h0,                 1,  0};
    vecs[3]  = '{"s_ovf",        1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 5};
    vecs[4]  = '{"u_max_1",      1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 0};
    vecs[5]  = '{"s_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0};
    vecs[6]  = '{"s_m7_m2",      1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33, 0};
    vecs[7]  = '{"u_big_2",      1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33, 0};
    vecs[8]  = '{"u_3_10",       1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 33, 0};
    vecs[9]  = '{"s_0_m5",       1'b1, 32'd0,          32'hFFFFFFFB,   64'h0,                 33, 0};
    vecs[10] = '{"u_hex",        1'b0, 32'h12345678,   32'h00001000,   64'h00000678_00012345, 33, 2};
    vecs[11] = '{"s_m100_0",     1'b1, 32'hFFFFFF9C,   32'd0,          64'h0,                 1,  3};

    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {63'b0, bus.ready_o}, 64'd0);
    check("reset result", bus.result_o, '0);
    check("reset state", {62'b0, dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);

    // Reset pulse while iterating, then a fresh operation on the first edge after release.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    check("rst_on state_before", {62'b0, dbg_state}, 64'd2);
    rst = 1'b0;
    #1;
    check("rst_on state", {62'b0, dbg_state}, 64'd0);
    check("rst_on ready", {63'b0, bus.ready_o}, 64'd0);
    check("rst_on result", bus.result_o, '0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 0);

    // Reset while holding a result in END clears outputs without waiting for a clock.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    lat = 0;
    while (!bus.ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_end ready_before", {63'b0, bus.ready_o}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_end ready", {63'b0, bus.ready_o}, 64'd0);
    check("rst_end result", bus.result_o, '0);
    check("rst_end state", {62'b0, dbg_state}, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef DIV_ANNUL_EN
    // Annul raised after E10 is taken at E11; annul while idle blocks acceptance.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul state", {62'b0, dbg_state}, 64'd0);
    check("annul ready", {63'b0, bus.ready_o}, 64'd0);
    @(negedge clk);
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    check("annul_idle state", {62'b0, dbg_state}, 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    run_op("annul_new", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);
`else
    // Without the annul feature an annul request mid-operation changes nothing.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    while (!bus.ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) bus.annul_i = 1'b1;
    end
    check("annul_ignored latency", 64'(lat), 64'd33);
    check("annul_ignored result", bus.result_o, 64'h00000002_0000000E);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_ignored release", {63'b0, bus.ready_o}, 64'd0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
